// File: rtl/instruction_fetch_pkg.sv
// Shared ISA constants for the fetch slice: data width, memory geometry,
// the canonical NOP encoding and the architectural reset vector.
package instruction_fetch_pkg;

    localparam int unsigned ISA_XLEN         = 32;
    localparam int unsigned ISA_WORD_ADDRESS = 30;
    localparam int unsigned ISA_MEM_SIZE     = 1024;
    localparam logic [31:0] ISA_NOP_INSTRUCTION = 32'h0000_0013;
    localparam logic [31:0] ISA_RESET_PC     = 32'h0000_0000;
    localparam int unsigned ISA_PC_STEP      = 4;
    localparam int unsigned ISA_FB_DEPTH     = 2;

    // Occupancy of the fetch buffer (0..2).
    typedef logic [1:0] fb_count_t;

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: instruction memory port, redirect input from EX and the
// valid/ready handshake toward decode.
interface instruction_fetch_if
    import instruction_fetch_pkg::*;
#(
    parameter int unsigned XLEN   = ISA_XLEN,
    parameter int unsigned ADDR_W = ISA_WORD_ADDRESS
);

    logic [ADDR_W-1:0] imem_address;
    logic [XLEN-1:0]   imem_instruction;
    logic              redirect_valid;
    logic [XLEN-1:0]   redirect_pc;
    logic              if_valid;
    logic              id_ready;
    logic [XLEN-1:0]   if_instruction;
    logic [XLEN-1:0]   if_pc;
    logic [31:0]       fetch_count;

    modport master (
        output imem_address,
        input  imem_instruction,
        input  redirect_valid,
        input  redirect_pc,
        output if_valid,
        input  id_ready,
        output if_instruction,
        output if_pc,
        output fetch_count
    );

    modport slave (
        input  imem_address,
        output imem_instruction,
        output redirect_valid,
        output redirect_pc,
        input  if_valid,
        output id_ready,
        input  if_instruction,
        input  if_pc,
        input  fetch_count
    );

endinterface

// File: rtl/instruction_fetch_buffer.sv
// Two-entry register FIFO of {pc, instruction}. Slot 0 is always the head,
// so head outputs come straight from registers. Empty reads as NOP / pc 0.
module fetch_buffer
    import instruction_fetch_pkg::*;
#(
    parameter int unsigned XLEN     = ISA_XLEN,
    parameter int unsigned FB_DEPTH = ISA_FB_DEPTH
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic            flush,
    input  logic [XLEN-1:0] push_pc,
    input  logic [XLEN-1:0] push_instruction,
    output fb_count_t       count,
    output logic            full,
    output logic            empty,
    output logic [XLEN-1:0] head_pc,
    output logic [XLEN-1:0] head_instruction
);

    fb_count_t       count_q;
    logic [XLEN-1:0] pc0, pc1, ins0, ins1;

    // Occupancy and slot update; flush wins over any push/pop in the same cycle.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            count_q <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        pc0  <= push_pc;
                        ins0 <= push_instruction;
                    end else begin
                        pc1  <= push_pc;
                        ins1 <= push_instruction;
                    end
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    pc0     <= pc1;
                    ins0    <= ins1;
                    count_q <= count_q - 2'd1;
                end
                2'b11: begin
                    // Head leaves and new word enters: with one entry the new
                    // word becomes the head, with two it queues behind slot 1.
                    if (count_q == 2'd1) begin
                        pc0  <= push_pc;
                        ins0 <= push_instruction;
                    end else begin
                        pc0  <= pc1;
                        ins0 <= ins1;
                        pc1  <= push_pc;
                        ins1 <= push_instruction;
                    end
                end
                default: ;
            endcase
        end
    end

    // Status and head presentation derived from registered state only.
    always_comb begin
        count            = count_q;
        empty            = (count_q == 2'd0);
        full             = (count_q == fb_count_t'(FB_DEPTH));
        head_pc          = '0;
        head_instruction = XLEN'(ISA_NOP_INSTRUCTION);
        if (!empty) begin
            head_pc          = pc0;
            head_instruction = ins0;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, drives the word address to instruction memory,
// buffers returned words and hands them to decode; EX redirects flush it.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = ISA_XLEN,
    parameter int unsigned     ADDR_W   = ISA_WORD_ADDRESS,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(ISA_RESET_PC),
    parameter int unsigned     FB_DEPTH = ISA_FB_DEPTH
) (
    input logic                 clk,
    input logic                 reset,
    instruction_fetch_if.master bus
);

    logic [XLEN-1:0] pc;
    logic [31:0]     fetch_count;
    logic [XLEN-1:0] redirect_target;
    logic            push, pop;
    logic            fb_full, fb_empty;
    fb_count_t       fb_count;
    logic [XLEN-1:0] head_pc, head_instruction;

    // Handshake arbitration: a redirect suppresses the push for its cycle.
    always_comb begin
        pop             = !fb_empty && bus.id_ready;
        push            = !bus.redirect_valid && (!fb_full || pop);
        redirect_target = bus.redirect_pc & ~XLEN'(3);
    end

    // PC and push counter; reset overrides a same-cycle redirect.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= {RESET_PC[XLEN-1:2], 2'b00};
            fetch_count <= '0;
        end else if (bus.redirect_valid) begin
            pc <= redirect_target;
        end else if (push) begin
            pc          <= pc + XLEN'(ISA_PC_STEP);
            fetch_count <= fetch_count + 32'd1;
        end
    end

    fetch_buffer #(
        .XLEN     (XLEN),
        .FB_DEPTH (FB_DEPTH)
    ) u_fetch_buffer (
        .clk              (clk),
        .reset            (reset),
        .push             (push),
        .pop              (pop),
        .flush            (bus.redirect_valid),
        .push_pc          (pc),
        .push_instruction (bus.imem_instruction),
        .count            (fb_count),
        .full             (fb_full),
        .empty            (fb_empty),
        .head_pc          (head_pc),
        .head_instruction (head_instruction)
    );

    // Outputs toward memory and decode, all sourced from registers.
    always_comb begin
        bus.imem_address   = pc[ADDR_W+1:2];
        bus.if_valid       = (fb_count != 2'd0);
        bus.if_instruction = head_instruction;
        bus.if_pc          = head_pc;
        bus.fetch_count    = fetch_count;
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed phases followed by a random phase,
// checked every cycle against a queue-based model of the fetch stage.
module tb_instruction_fetch;
    import instruction_fetch_pkg::*;

    localparam logic [31:0] NOP = ISA_NOP_INSTRUCTION;

    logic clk;
    logic reset;
    int   n_cmp = 0;
    int   n_mis = 0;

    instruction_fetch_if #(.XLEN(32), .ADDR_W(30)) bus ();

    instruction_fetch #(
        .XLEN     (32),
        .ADDR_W   (30),
        .RESET_PC (32'h0000_0000),
        .FB_DEPTH (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Combinational instruction memory; beyond MEM_SIZE words it returns NOP.
    logic [31:0] mem [ISA_MEM_SIZE];
    logic [9:0]  mem_idx;
    assign mem_idx = bus.imem_address[9:0];
    assign bus.imem_instruction =
        (bus.imem_address < 30'(ISA_MEM_SIZE)) ? mem[mem_idx] : NOP;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: queue of fetched {pc, word} plus the next fetch pc.
    logic [31:0] q_pc [$];
    logic [31:0] q_ins [$];
    logic [31:0] m_pc;
    logic [31:0] m_fc;

    function automatic logic [31:0] mem_word(input logic [31:0] byte_pc);
        logic [31:0] widx;
        widx = byte_pc >> 2;
        if (widx < ISA_MEM_SIZE) return mem[widx[9:0]];
        return NOP;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply inputs for one cycle, compare outputs to the model, advance both.
    task automatic cycle(input logic rst, input logic rdy, input logic rv,
                         input logic [31:0] rpc);
        int  sz;
        logic do_pop;
        reset              = rst;
        bus.id_ready       = rdy;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        #1;
        sz = q_pc.size();
        check("if_valid",       {31'b0, bus.if_valid}, {31'b0, sz > 0});
        check("if_pc",          bus.if_pc,             (sz > 0) ? q_pc[0]  : 32'h0);
        check("if_instruction", bus.if_instruction,    (sz > 0) ? q_ins[0] : NOP);
        check("fetch_count",    bus.fetch_count,       m_fc);
        check("imem_address",   {2'b00, bus.imem_address}, {2'b00, m_pc[31:2]});
        if (rst) begin
            q_pc.delete();
            q_ins.delete();
            m_pc = ISA_RESET_PC & ~32'd3;
            m_fc = 0;
        end else begin
            do_pop = (sz > 0) && rdy;
            if (rv) begin
                q_pc.delete();
                q_ins.delete();
                m_pc = rpc & ~32'd3;
            end else begin
                if (do_pop) begin
                    void'(q_pc.pop_front());
                    void'(q_ins.pop_front());
                end
                if (sz < 2 || do_pop) begin
                    q_pc.push_back(m_pc);
                    q_ins.push_back(mem_word(m_pc));
                    m_pc = m_pc + 32'd4;
                    m_fc = m_fc + 32'd1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < ISA_MEM_SIZE; i++) mem[i] = $urandom;
        mem[0] = 32'h0050_0093;
        mem[1] = 32'h00A0_0113;
        mem[2] = 32'h00F0_0193;

        reset              = 1'b1;
        bus.id_ready       = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        m_pc = 0;
        m_fc = 0;
        repeat (2) @(posedge clk);
        #1;

        // Reset held, then release with decode always ready.
        repeat (2) cycle(1'b1, 1'b1, 1'b0, 32'h0);
        repeat (6) cycle(1'b0, 1'b1, 1'b0, 32'h0);

        // Fresh reset, decode stalled: buffer fills and PC holds, then drains.
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        repeat (4) cycle(1'b0, 1'b0, 1'b0, 32'h0);
        repeat (5) cycle(1'b0, 1'b1, 1'b0, 32'h0);

        // Redirect while full and stalled; unaligned target 0x43 -> 0x40.
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 1'b1, 32'h43);
        repeat (5) cycle(1'b0, 1'b1, 1'b0, 32'h0);

        // Redirect with a same-cycle pop at count 1 (steady streaming).
        cycle(1'b0, 1'b1, 1'b1, 32'h100);
        repeat (4) cycle(1'b0, 1'b1, 1'b0, 32'h0);

        // Reset mid-stream with two buffered entries and a redirect pending.
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 1'b1, 32'h80);
        repeat (3) cycle(1'b0, 1'b1, 1'b0, 32'h0);

        // PC wrap through the top of the address space (out-of-range -> NOP).
        cycle(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF4);
        repeat (7) cycle(1'b0, 1'b1, 1'b0, 32'h0);

        // Back-to-back redirects: the last one wins.
        cycle(1'b0, 1'b1, 1'b1, 32'h200);
        cycle(1'b0, 1'b1, 1'b1, 32'h300);
        repeat (4) cycle(1'b0, 1'b1, 1'b0, 32'h0);

        // Random traffic: stalls, redirects (some unaligned or out of range), resets.
        for (int i = 0; i < 400; i++) begin
            logic        r_rst, r_rdy, r_rv;
            logic [31:0] r_pc;
            r_rst = ($urandom_range(0, 59) == 0);
            r_rdy = ($urandom_range(0, 2) != 0);
            r_rv  = ($urandom_range(0, 11) == 0);
            r_pc  = ($urandom_range(0, 7) == 0) ? $urandom
                                                : 32'($urandom_range(0, 4 * 1100));
            cycle(r_rst, r_rdy, r_rv, r_pc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Fetch stage; the initiator side of the instruction memory interface.
- Owns the PC and drives a word address to the combinational instruction memory.
- Captures the returned word into a 2-entry fetch buffer.
- Presents instructions to decode with a valid/ready handshake.
- Handles redirects (branch/jump from EX) by flushing the buffer and reloading the PC.

Parameters:
XLEN, `XLEN (32), data/PC width
ADDR_W, `WORD_ADDRESS, word-address width driven to instruction memory
RESET_PC, 32'h0000_0000, byte address fetched first after reset
FB_DEPTH, 2, fetch buffer entries (fixed at 2; not a general FIFO depth)

Ports:
clk  input  1  rising-edge clock, single domain
reset  input  1  synchronous, active-high
imem_address  output  ADDR_W  word address = pc[ADDR_W+1:2]
imem_instruction  input  XLEN  word returned combinationally, same cycle
redirect_valid  input  1  redirect request from EX, single-cycle pulse
redirect_pc  input  XLEN  byte target; bits [1:0] ignored
if_valid  output  1  head entry valid toward decode
id_ready  input  1  decode accepts head this cycle
if_instruction  output  XLEN  head instruction; `NOP_INSTRUCTION when empty
if_pc  output  XLEN  byte PC of head instruction; 0 when empty
fetch_count  output  32  number of words pushed into buffer; wraps at 2^32

Behaviour:
- Reset (sampled at posedge with reset=1):
  - pc <= RESET_PC with bits [1:0] cleared; count <= 0; fetch_count <= 0.
  - if_valid=0, if_instruction=`NOP_INSTRUCTION, if_pc=0.
  - Reset mid-operation discards all buffered entries and any same-cycle redirect.
- Address: imem_address is pc[ADDR_W+1:2], combinational from the pc register.
- PC overflow: pc wraps modulo 2^XLEN. Out-of-range addresses return NOP from memory; this block does no range check.
- Handshake:
  - pop = if_valid & id_ready.
  - push = !redirect_valid & (count<2 | pop).
- On push:
  - Write {pc, imem_instruction} at the tail.
  - pc <= pc+4; fetch_count <= fetch_count+1.
- Buffer update:
  - push & pop: count unchanged; head advances.
  - pop only: count-1.
  - push only: count+1.
- Full (count=2, no pop): no push; pc and imem_address hold.
- Empty: if_valid=0, if_instruction=NOP, if_pc=0. An empty buffer never bypasses the memory word straight to the outputs; every instruction spends at least one cycle in the buffer.
- Latency:
  - The word at pc in cycle N is visible on if_* in cycle N+1.
  - Steady state with id_ready=1 gives 1 instruction/cycle.
  - After reset deasserts in cycle R, if_valid is first 1 in cycle R+1 with if_pc=RESET_PC.
- Redirect (redirect_valid=1 at posedge):
  - count <= 0, discarding entries including any same-cycle pop target.
  - pc <= {redirect_pc[XLEN-1:2],2'b00}; no push that cycle.
  - Decode may still see if_valid=1 combinationally in that cycle. A pop in that cycle is legal and counts as consumed; upstream is responsible for squashing that instruction.
  - First redirected instruction appears on if_* two cycles after the redirect edge.
- Back-to-back redirects: the last one wins; each flushes.
- Outputs if_valid/if_instruction/if_pc are driven only from buffer registers, with no combinational path from id_ready or redirect_valid.

Decomposition:
- Shared header isa.v:
  - Existing: `XLEN, `WORD_ADDRESS, `MEM_SIZE, `NOP_INSTRUCTION.
  - Add: `RESET_PC and `PC_STEP (4).
- Sub-module fetch_buffer:
  - 2-entry register FIFO of {pc, instruction} with push, pop, flush.
  - Outputs: count/full/empty, head data.
- instruction_fetch holds the PC, push/pop arbitration and the counter.

Test Plan:
- Reset release, memory words 0x00500093, 0x00A00113, …, id_ready=1 -> if_valid=1 from cycle R+1; if_pc 0x0,0x4,0x8 on consecutive cycles; fetch_count=3 after 3 pushes.
- id_ready=0 after reset -> buffer fills (if_pc=0x0 held); imem_address holds 2 and pc holds 0x8. Raise id_ready -> outputs 0x0,0x4,0x8 in order with no gap or duplicate.
- redirect_valid with redirect_pc=0x43 while full and stalled -> if_valid=0 next cycle; then if_pc=0x40 and imem_address=0x10, and sequence continues 0x44.
- Same-cycle redirect and pop at count=1 -> pop accepted; count=0 next cycle; no push; fetch_count unchanged that cycle.
- Reset asserted mid-stream with count=2 -> next cycle if_valid=0, if_instruction=0x00000013, fetch_count=0, imem_address=RESET_PC>>2.
- pc=0xFFFFFFFC with id_ready=1 -> next push uses pc 0x00000000 (wrap); out-of-range fetch delivers `NOP_INSTRUCTION with correct if_pc.
